// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller constants: T-state encodings, opcodes and control-word bit layout.
package sap1_pkg;

  typedef enum logic [5:0] {
    T1 = 6'b100000,
    T2 = 6'b010000,
    T3 = 6'b001000,
    T4 = 6'b000100,
    T5 = 6'b000010,
    T6 = 6'b000001
  } tstate_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // con = {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam int CW_W    = 12;
  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  localparam logic [CW_W-1:0] CW_NOP = 12'h3E3;

  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_control_unit_if.sv
// Ring/IR inputs and control outputs of the SAP-1 controller-sequencer.
interface sap1_control_unit_if #(
  parameter int OPC_W = 4,
  parameter int CNT_W = 8
);
  logic [5:0]       t;
  logic [OPC_W-1:0] opcode;
  logic [11:0]      con;
  logic             hlt;
  logic             seq_err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (output t, opcode, input con, hlt, seq_err, instr_cnt);
  modport slave  (input t, opcode, output con, hlt, seq_err, instr_cnt);
endinterface

// File: rtl/sap1_cw_decode.sv
// Pure combinational {T-state, opcode} -> control word; anything not one-hot decodes to NOP.
module sap1_cw_decode
  import sap1_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [5:0]       t,
  input  logic [OPC_W-1:0] opcode,
  output logic [CW_W-1:0]  con
);

  logic [3:0] op;
  assign op = 4'(opcode);

  // Start from NOP and toggle only the signals asserted in each microstep.
  always_comb begin
    con = CW_NOP;
    case (t)
      T1: begin
        con[CW_EP]   = 1'b1;
        con[CW_LM_N] = 1'b0;
      end
      T2: con[CW_CP] = 1'b1;
      T3: begin
        con[CW_CE_N] = 1'b0;
        con[CW_LI_N] = 1'b0;
      end
      T4: begin
        if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin
          con[CW_LM_N] = 1'b0;
          con[CW_EI_N] = 1'b0;
        end else if (op == OP_OUT) begin
          con[CW_EA]   = 1'b1;
          con[CW_LO_N] = 1'b0;
        end
      end
      T5: begin
        if (op == OP_LDA) begin
          con[CW_CE_N] = 1'b0;
          con[CW_LA_N] = 1'b0;
        end else if (op == OP_ADD || op == OP_SUB) begin
          con[CW_CE_N] = 1'b0;
          con[CW_LB_N] = 1'b0;
        end
      end
      T6: begin
        if (op == OP_ADD || op == OP_SUB) begin
          con[CW_LA_N] = 1'b0;
          con[CW_EU]   = 1'b1;
          con[CW_SU]   = (op == OP_SUB);
        end
      end
      default: con = CW_NOP;
    endcase
  end

endmodule

// File: rtl/sap1_control_unit.sv
// SAP-1 controller-sequencer: control-word decode, HLT latch, ring checker, retire counter.
// Define SAP1_ILLEGAL_TRAP_EN to halt on undefined opcodes instead of treating them as NOP.
module sap1_control_unit
  import sap1_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               res_n,
  sap1_control_unit_if.slave bus
);

  logic [CW_W-1:0]  cw_raw;
  logic             t_onehot;
  logic             halt_op;
  logic             hlt_q, hlt_d;
  logic             seq_err_q, seq_err_d;
  logic [5:0]       exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sap1_cw_decode #(.OPC_W(OPC_W)) u_decode (
    .t      (bus.t),
    .opcode (bus.opcode),
    .con    (cw_raw)
  );

  assign t_onehot = is_onehot6(bus.t);

`ifdef SAP1_ILLEGAL_TRAP_EN
  assign halt_op = (4'(bus.opcode) == OP_HLT) || !is_defined_op(4'(bus.opcode));
`else
  assign halt_op = (4'(bus.opcode) == OP_HLT);
`endif

  // The halt decode preempts the ring check and retire on its own edge.
  always_comb begin
    hlt_d     = hlt_q;
    seq_err_d = seq_err_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    if (!hlt_q) begin
      if (bus.t == T4 && halt_op) begin
        hlt_d = 1'b1;
      end else begin
        exp_d = {exp_q[0], exp_q[5:1]};
        if (bus.t != exp_q || !t_onehot) seq_err_d = 1'b1;
        if (bus.t == T6) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State advances on the falling edge, in step with the ring counter.
  always_ff @(negedge clk or negedge res_n) begin
    if (!res_n) begin
      hlt_q     <= 1'b0;
      seq_err_q <= 1'b0;
      exp_q     <= T1;
      cnt_q     <= '0;
    end else begin
      hlt_q     <= hlt_d;
      seq_err_q <= seq_err_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.con       = (hlt_q || !t_onehot || !res_n) ? CW_NOP : cw_raw;
  assign bus.hlt       = hlt_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_sap1_control_unit.sv
// Scoreboard bench for sap1_control_unit: directed T-state/opcode vectors, expected words queued by the driver.
module tb_sap1_control_unit;
  import sap1_pkg::*;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  sap1_control_unit_if #(.OPC_W(4), .CNT_W(8)) ia ();
  sap1_control_unit_if #(.OPC_W(4), .CNT_W(2)) ib ();

  sap1_control_unit #(.OPC_W(4), .CNT_W(8)) dut_a (.clk(clk), .res_n(res_n), .bus(ia));
  sap1_control_unit #(.OPC_W(4), .CNT_W(2)) dut_b (.clk(clk), .res_n(res_n), .bus(ib));

  typedef struct {
    logic [11:0] con;
    logic        hlt;
    logic        seq;
    int          cnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // One clock period: drive inputs just after posedge, queue the expected response.
  task automatic step(input logic [5:0] tv, input logic [3:0] op, input logic rst_low,
                      input logic [11:0] c, input logic h, input logic s,
                      input int cnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    ia.t = tv; ia.opcode = op;
    ib.t = tv; ib.opcode = op;
    res_n = !rst_low;
    e.con = c; e.hlt = h; e.seq = s; e.cnt = cnt; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [11:0] c4, input logic [11:0] c5,
                           input logic [11:0] c6, input int base, input logic halts,
                           input string nm);
    int fin;
    fin = halts ? base : base + 1;
    step(T1, op, 1'b0, 12'h5E3, 1'b0, 1'b0, base, {nm, ".T1"});
    step(T2, op, 1'b0, 12'hBE3, 1'b0, 1'b0, base, {nm, ".T2"});
    step(T3, op, 1'b0, 12'h263, 1'b0, 1'b0, base, {nm, ".T3"});
    step(T4, op, 1'b0, c4,      halts, 1'b0, base, {nm, ".T4"});
    step(T5, op, 1'b0, c5,      halts, 1'b0, base, {nm, ".T5"});
    step(T6, op, 1'b0, c6,      halts, 1'b0, fin,  {nm, ".T6"});
  endtask

  task automatic do_reset(input string nm);
    step(T1, OP_LDA, 1'b1, CW_NOP, 1'b0, 1'b0, 0, nm);
  endtask

  // Monitor: con is checked mid-high-phase, registered state just after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".con"}, 32'(ia.con), 32'(e.con));
        @(negedge clk);
        #1;
        chk({e.nm, ".hlt"},     32'(ia.hlt),       32'(e.hlt));
        chk({e.nm, ".seq_err"}, 32'(ia.seq_err),   32'(e.seq));
        chk({e.nm, ".cnt8"},    32'(ia.instr_cnt), 32'(e.cnt % 256));
        chk({e.nm, ".cnt2"},    32'(ib.instr_cnt), 32'(e.cnt % 4));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ia.t = T1; ia.opcode = OP_LDA;
    ib.t = T1; ib.opcode = OP_LDA;

    do_reset("rst0");
    run_instr(OP_LDA, 12'h1A3, 12'h2C3, 12'h3E3, 0, 1'b0, "lda");

    do_reset("rst1");
    run_instr(OP_ADD, 12'h1A3, 12'h2E1, 12'h3C7, 0, 1'b0, "add");
    run_instr(OP_SUB, 12'h1A3, 12'h2E1, 12'h3CF, 1, 1'b0, "sub");

    do_reset("rst2");
    run_instr(OP_OUT, 12'h3F2, CW_NOP, CW_NOP, 0, 1'b0, "out");
    run_instr(OP_HLT, CW_NOP, CW_NOP, CW_NOP, 1, 1'b1, "hlt");
    step(T1, OP_LDA, 1'b0, CW_NOP, 1'b1, 1'b0, 1, "halted.T1");
    step(T2, OP_LDA, 1'b0, CW_NOP, 1'b1, 1'b0, 1, "halted.T2");
    step(T4, OP_HLT, 1'b0, CW_NOP, 1'b1, 1'b0, 1, "halted.T4");

    // Ring faults: wrong one-hot, then non-one-hot; exp drifts back into step at T3.
    do_reset("rst3");
    step(6'b010000, OP_LDA, 1'b0, 12'hBE3, 1'b0, 1'b1, 0, "seq.bad");
    step(6'b110000, OP_LDA, 1'b0, CW_NOP,  1'b0, 1'b1, 0, "seq.multi");
    step(T3, OP_LDA, 1'b0, 12'h263, 1'b0, 1'b1, 0, "seq.T3");
    step(T4, OP_LDA, 1'b0, 12'h1A3, 1'b0, 1'b1, 0, "seq.T4");
    step(T5, OP_LDA, 1'b0, 12'h2C3, 1'b0, 1'b1, 0, "seq.T5");
    step(T6, OP_LDA, 1'b0, 12'h3E3, 1'b0, 1'b1, 1, "seq.T6");

    // Reset asserted mid-instruction at T3.
    step(T1, OP_LDA, 1'b0, 12'h5E3, 1'b0, 1'b1, 1, "mid.T1");
    step(T2, OP_LDA, 1'b0, 12'hBE3, 1'b0, 1'b1, 1, "mid.T2");
    step(T3, OP_LDA, 1'b1, CW_NOP,  1'b0, 1'b0, 0, "mid.rst");

    for (int i = 0; i < 5; i++)
      run_instr(OP_LDA, 12'h1A3, 12'h2C3, 12'h3E3, i, 1'b0, $sformatf("wrap%0d", i));

    do_reset("rst4");
`ifdef SAP1_ILLEGAL_TRAP_EN
    run_instr(4'b0101, CW_NOP, CW_NOP, CW_NOP, 0, 1'b1, "ill");
`else
    run_instr(4'b0101, CW_NOP, CW_NOP, CW_NOP, 0, 1'b0, "ill");
`endif
    do_reset("rst5");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
